// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: prescaled LED pattern sequencer with run/hold/idle FSM and colour bank select
module led_seq_ctrl #(
  parameter int NB_LEDS    = 4,
  parameter int NB_COUNTER = 32,
  parameter int NB_SPEED   = 3,
  parameter int BASE_LIMIT = 2**20
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_hold,
  input  logic [1:0]          i_mode,
  input  logic [NB_SPEED-1:0] i_speed_sel,
  input  logic                i_btn_color,
  output logic [NB_LEDS-1:0]  o_led,
  output logic [NB_LEDS-1:0]  o_led_g,
  output logic [NB_LEDS-1:0]  o_led_b,
  output logic                o_tick,
  output logic [1:0]          o_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_t;
  state_t state, state_n;
  logic [NB_COUNTER-1:0] cnt, cnt_n, limit;
  logic [NB_LEDS-1:0] led_n, seed, step;
  logic dir, dir_n, step_dir, colour, colour_n, tick_n, btn_prev, turn;
  logic [1:0] mode_prev;
  logic [NB_SPEED-1:0] speed_prev;
  logic mode_chg, speed_chg, at_end;
  assign limit = NB_COUNTER'(BASE_LIMIT) << i_speed_sel;
  // >= keeps the counter bounded if the limit shrinks while held
  assign at_end = cnt + NB_COUNTER'(1) >= limit;
  assign mode_chg = i_mode != mode_prev;
  assign speed_chg = i_speed_sel != speed_prev;
  assign o_state = state;
  assign seed = i_mode == 2'b11 ? '1 :
                i_mode == 2'b01 ? {1'b1, {(NB_LEDS-1){1'b0}}} : NB_LEDS'(1);
  // dir=1 means moving toward the MSB; reaching the end in that direction reverses it
  assign turn = dir ? o_led[NB_LEDS-1] : o_led[0];
  always_comb begin
    step = o_led;
    step_dir = dir;
    case (i_mode)
      2'b00: step = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
      2'b01: step = {o_led[0], o_led[NB_LEDS-1:1]};
      2'b10: begin
        step_dir = dir ^ turn;
        step = step_dir ? o_led << 1 : o_led >> 1;
      end
      default: step = ~o_led;
    endcase
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    led_n = o_led;
    dir_n = dir;
    tick_n = 1'b0;
    colour_n = colour ^ (i_btn_color & ~btn_prev);
    if (!i_enable) begin
      state_n = IDLE;
      cnt_n = '0;
      led_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = LOAD;
          cnt_n = '0;
          led_n = '0;
        end
        LOAD: begin
          state_n = RUN;
          cnt_n = '0;
          led_n = seed;
          dir_n = 1'b1;
        end
        RUN: begin
          if (mode_chg) state_n = LOAD;
          else if (i_hold) state_n = HOLD;
          else if (speed_chg) cnt_n = '0;
          else if (at_end) begin
            cnt_n = '0;
            tick_n = 1'b1;
            led_n = step;
            dir_n = step_dir;
          end else cnt_n = cnt + NB_COUNTER'(1);
        end
        default: state_n = mode_chg ? LOAD : i_hold ? HOLD : RUN;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      o_led <= '0;
      o_led_g <= '0;
      o_led_b <= '0;
      o_tick <= 1'b0;
      dir <= 1'b1;
      colour <= 1'b0;
      btn_prev <= 1'b0;
      mode_prev <= '0;
      speed_prev <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_led <= led_n;
      o_led_g <= colour_n ? '0 : led_n;
      o_led_b <= colour_n ? led_n : '0;
      o_tick <= tick_n;
      dir <= dir_n;
      colour <= colour_n;
      btn_prev <= i_btn_color;
      mode_prev <= i_mode;
      speed_prev <= i_speed_sel;
    end
  end
endmodule
